qam_iq_upsampler: RTL and testbench

QAM_IQ_UPSAMPLER -- requirements
Module: qam_iq_upsampler

---
 rtl/qam_iq_upsampler_if.sv | 27 ++
 rtl/qam_iq_upsampler.sv | 106 ++++++++++
 tb/tb_qam_iq_upsampler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_iq_upsampler_if.sv
// QAM upsampler stream bundle: symbol input side, sample output side and control.
// Ports: signal_in/valid_in/ready_out (symbol in), signal_out/valid_out/ready_in/sym_start (samples out),
//        sps/mode (per-symbol config), error (illegal sps flag). master = upstream/downstream env, slave = upsampler.
interface qam_iq_upsampler_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] signal_in;
  logic              valid_in;
  logic              ready_out;
  logic [4:0]        sps;
  logic              mode;
  logic [DATA_W-1:0] signal_out;
  logic              valid_out;
  logic              ready_in;
  logic              sym_start;
  logic              error;

  modport master (
    output signal_in, valid_in, sps, mode, ready_in,
    input  ready_out, signal_out, valid_out, sym_start, error
  );

  modport slave (
    input  signal_in, valid_in, sps, mode, ready_in,
    output ready_out, signal_out, valid_out, sym_start, error
  );
endinterface

// File: rtl/qam_iq_upsampler.sv
// I/Q symbol upsampler: each accepted symbol becomes sps samples (hold or zero-stuff).
// Latency 1 cycle from symbol accept to first sample; outputs hold while stalled.
// ready_out is combinational so a new symbol lands in the same cycle the last sample leaves.
module qam_iq_upsampler #(
  parameter int DATA_W  = 32,
  parameter int SPS_MAX = 16
) (
  input logic                clk,
  input logic                rst,
  qam_iq_upsampler_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [4:0]        phase;
  logic [4:0]        sps_q;
  logic              mode_q;
  logic [DATA_W-1:0] sym_q;
  logic [DATA_W-1:0] dat_q;
  logic              ss_q;
  logic              err_q;

  logic sps_legal;
  logic last_phase;
  logic valid_o;
  logic ready_o;
  logic in_acc;
  logic out_acc;

  assign sps_legal  = (bus.sps != 5'd0) && (int'(bus.sps) <= SPS_MAX);
  assign last_phase = (phase == (sps_q - 5'd1));
  assign in_acc     = bus.valid_in & ready_o;
  assign out_acc    = valid_o & bus.ready_in;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_acc) state_nxt = EMIT;
      EMIT: if (out_acc && last_phase && !in_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. The live sps is checked even in EMIT so an illegal value
  // blocks the follow-on symbol and the FSM falls back to IDLE.
  // Gating with rst keeps ready_out low for the whole reset window.
  always_comb begin
    valid_o = (state == EMIT);
    ready_o = 1'b0;
    case (state)
      IDLE: ready_o = sps_legal;
      EMIT: ready_o = last_phase & bus.ready_in & sps_legal;
      default: ready_o = 1'b0;
    endcase
    ready_o = ready_o & rst;
  end

  // Datapath: latch symbol/config on accept, step phase on each output accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= 5'd0;
      sps_q  <= 5'd0;
      mode_q <= 1'b0;
      sym_q  <= '0;
      dat_q  <= '0;
      ss_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= ~sps_legal;
      if (in_acc) begin
        sym_q  <= bus.signal_in;
        sps_q  <= bus.sps;
        mode_q <= bus.mode;
        phase  <= 5'd0;
        dat_q  <= bus.signal_in;
        ss_q   <= 1'b1;
      end else if (out_acc) begin
        if (last_phase) begin
          phase <= 5'd0;
          dat_q <= '0;
          ss_q  <= 1'b0;
        end else begin
          phase <= phase + 5'd1;
          dat_q <= mode_q ? '0 : sym_q;
          ss_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.signal_out = dat_q;
  assign bus.valid_out  = valid_o;
  assign bus.sym_start  = ss_q;
  assign bus.ready_out  = ready_o;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_qam_iq_upsampler.sv
// Directed bench for qam_iq_upsampler with a queue scoreboard and independent output monitor.
// Stimulus pushes hand-computed samples; the monitor pops on every valid&ready and checks stall hold.
module tb_qam_iq_upsampler;

  logic clk;
  logic rst;

  qam_iq_upsampler_if #(.DATA_W(32)) bus ();

  qam_iq_upsampler #(.DATA_W(32), .SPS_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        ss;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  int   base  = 0;

  logic        stall_prev = 1'b0;
  logic [31:0] prev_dat   = '0;
  logic        prev_ss    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic s);
    exp_t e;
    e.dat = d;
    e.ss  = s;
    exp_q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (stall_prev) begin
      chk("hold_vld", 32'(bus.valid_out), 32'd1);
      chk("hold_dat", bus.signal_out, prev_dat);
      chk("hold_ss", 32'(bus.sym_start), 32'(prev_ss));
    end
    if (bus.valid_out && bus.ready_in) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sample: got %h want none", bus.signal_out);
      end else begin
        e = exp_q.pop_front();
        chk("sample_dat", bus.signal_out, e.dat);
        chk("sample_ss", 32'(bus.sym_start), 32'(e.ss));
      end
    end
    stall_prev = bus.valid_out && !bus.ready_in && rst;
    prev_dat   = bus.signal_out;
    prev_ss    = bus.sym_start;
  end

  initial begin
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    rst           = 1'b0;
    bus.signal_in = '0;
    bus.valid_in  = 1'b0;
    bus.sps       = 5'd4;
    bus.mode      = 1'b0;
    bus.ready_in  = 1'b1;

    // Reset state
    step;
    step;
    chk("rst_vld", 32'(bus.valid_out), 32'd0);
    chk("rst_dat", bus.signal_out, 32'd0);
    chk("rst_ss", 32'(bus.sym_start), 32'd0);
    chk("rst_err", 32'(bus.error), 32'd0);
    chk("rst_rdy", 32'(bus.ready_out), 32'd0);
    rst = 1'b1;

    // T1: sps=4 hold; config change mid-symbol must not matter
    bus.signal_in = 32'h1234_ABCD;
    bus.valid_in  = 1'b1;
    push(32'h1234_ABCD, 1'b1);
    for (int i = 0; i < 3; i++) push(32'h1234_ABCD, 1'b0);
    @(negedge clk);
    chk("t1_rdy", 32'(bus.ready_out), 32'd1);
    step;
    bus.valid_in = 1'b0;
    bus.sps      = 5'd2;
    bus.mode     = 1'b1;
    base         = n_acc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_vld", 32'(bus.valid_out), 32'd1);
      step;
    end
    @(negedge clk);
    chk("t1_drop", 32'(bus.valid_out), 32'd0);
    step;
    chk("t1_count", 32'(n_acc - base), 32'd4);

    // T2: sps=4 zero-stuff, two symbols back-to-back
    bus.sps       = 5'd4;
    bus.mode      = 1'b1;
    bus.signal_in = 32'h0001_0002;
    bus.valid_in  = 1'b1;
    push(32'h0001_0002, 1'b1);
    for (int i = 0; i < 3; i++) push(32'h0, 1'b0);
    push(32'h0003_0004, 1'b1);
    for (int i = 0; i < 3; i++) push(32'h0, 1'b0);
    @(negedge clk);
    chk("t2_rdy0", 32'(bus.ready_out), 32'd1);
    step;
    bus.signal_in = 32'h0003_0004;
    base          = n_acc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_nogap", 32'(bus.valid_out), 32'd1);
      if (i <= 3) chk("t2_rdy", 32'(bus.ready_out), 32'(i == 3));
      step;
      if (i == 3) bus.valid_in = 1'b0;
    end
    @(negedge clk);
    chk("t2_drop", 32'(bus.valid_out), 32'd0);
    step;
    chk("t2_count", 32'(n_acc - base), 32'd8);

    // T3: sps=3 with downstream stalls
    bus.sps       = 5'd3;
    bus.mode      = 1'b0;
    bus.signal_in = 32'hCAFE_0003;
    bus.valid_in  = 1'b1;
    push(32'hCAFE_0003, 1'b1);
    push(32'hCAFE_0003, 1'b0);
    push(32'hCAFE_0003, 1'b0);
    @(negedge clk);
    chk("t3_rdy0", 32'(bus.ready_out), 32'd1);
    step;
    bus.valid_in = 1'b0;
    base         = n_acc;
    for (int k = 0; k < 6; k++) begin
      bus.ready_in = pat[k][0];
      @(negedge clk);
      chk("t3_rdy", 32'(bus.ready_out), 32'(k == 5));
      step;
    end
    bus.ready_in = 1'b1;
    @(negedge clk);
    chk("t3_drop", 32'(bus.valid_out), 32'd0);
    step;
    chk("t3_count", 32'(n_acc - base), 32'd3);

    // T4: sps=1 streaming, one symbol per cycle
    bus.sps  = 5'd1;
    bus.mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.signal_in = 32'h100 + 32'(i);
      bus.valid_in  = 1'b1;
      push(32'h100 + 32'(i), 1'b1);
      @(negedge clk);
      chk("t4_rdy", 32'(bus.ready_out), 32'd1);
      if (i > 0) begin
        chk("t4_vld", 32'(bus.valid_out), 32'd1);
        chk("t4_delay", bus.signal_out, 32'h100 + 32'(i - 1));
      end
      step;
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("t4_last", bus.signal_out, 32'h107);
    step;
    @(negedge clk);
    chk("t4_drop", 32'(bus.valid_out), 32'd0);
    step;

    // T5: illegal sps=0, then recover with sps=2
    bus.sps       = 5'd0;
    bus.signal_in = 32'h5555_AAAA;
    bus.valid_in  = 1'b1;
    @(negedge clk);
    chk("t5_err_pre", 32'(bus.error), 32'd0);
    chk("t5_rdy_pre", 32'(bus.ready_out), 32'd0);
    step;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_err", 32'(bus.error), 32'd1);
      chk("t5_rdy", 32'(bus.ready_out), 32'd0);
      chk("t5_noout", 32'(bus.valid_out), 32'd0);
      step;
    end
    push(32'h5555_AAAA, 1'b1);
    push(32'h5555_AAAA, 1'b0);
    bus.sps = 5'd2;
    base    = n_acc;
    @(negedge clk);
    chk("t5_err_lag", 32'(bus.error), 32'd1);
    chk("t5_rdy_ok", 32'(bus.ready_out), 32'd1);
    step;
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("t5_err_clr", 32'(bus.error), 32'd0);
    chk("t5_vld", 32'(bus.valid_out), 32'd1);
    step;
    step;
    @(negedge clk);
    chk("t5_drop", 32'(bus.valid_out), 32'd0);
    step;
    chk("t5_count", 32'(n_acc - base), 32'd2);

    // T6: reset at phase 2 of an sps=8 symbol
    bus.sps       = 5'd8;
    bus.signal_in = 32'h8888_7777;
    bus.valid_in  = 1'b1;
    push(32'h8888_7777, 1'b1);
    for (int i = 0; i < 7; i++) push(32'h8888_7777, 1'b0);
    @(negedge clk);
    chk("t6_rdy0", 32'(bus.ready_out), 32'd1);
    step;
    bus.valid_in = 1'b0;
    base         = n_acc;
    step;
    step;
    rst = 1'b0;
    #1;
    chk("t6_rst_dat", bus.signal_out, 32'd0);
    chk("t6_rst_vld", 32'(bus.valid_out), 32'd0);
    chk("t6_rst_ss", 32'(bus.sym_start), 32'd0);
    chk("t6_rst_rdy", 32'(bus.ready_out), 32'd0);
    chk("t6_pre_count", 32'(n_acc - base), 32'd2);
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_hold", 32'(bus.valid_out), 32'd0);
    step;
    rst           = 1'b1;
    bus.signal_in = 32'h1111_2222;
    bus.valid_in  = 1'b1;
    push(32'h1111_2222, 1'b1);
    for (int i = 0; i < 7; i++) push(32'h1111_2222, 1'b0);
    base = n_acc;
    @(negedge clk);
    chk("t6_rdy_post", 32'(bus.ready_out), 32'd1);
    step;
    bus.valid_in = 1'b0;
    repeat (8) step;
    @(negedge clk);
    chk("t6_drop", 32'(bus.valid_out), 32'd0);
    step;
    chk("t6_count", 32'(n_acc - base), 32'd8);

    step;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
